// File: rtl/encode_thermo.sv
// Thermometer-mask to count encoder with legality check behind valid/ready handshakes.
// Define ENC_THERMO_FAST_EN for single-cycle evaluation; otherwise masks are scanned CHUNK_W bits per cycle.
module encode_thermo #(
  parameter int CHUNK_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] mask_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [4:0]  n_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Accumulator layout: {err, seen_zero, cnt[4:0]}; one mask bit folded in per call.
  function automatic logic [6:0] f_step(input logic [6:0] acc, input logic bit_v, input logic is_top);
    logic [6:0] res;
    res = acc;
    if (is_top) begin
      res[6] = acc[6] | bit_v;
    end else if (bit_v) begin
      if (acc[5]) begin
        res[6] = 1'b1;
      end else begin
        res[4:0] = acc[4:0] + 5'd1;
      end
    end else begin
      res[5] = 1'b1;
    end
    return res;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ready;
  logic        r_valid;
  logic [4:0]  r_n;
  logic        r_err;
  logic        w_load;
  logic [5:0]  w_res;

`ifdef ENC_THERMO_FAST_EN
  function automatic logic [6:0] f_full(input logic [31:0] mask);
    logic [6:0] acc;
    acc = 7'd0;
    for (int i = 0; i < 32; i++) begin
      acc = f_step(acc, mask[i], i == 31);
    end
    return acc;
  endfunction

  logic [6:0] w_full;
  assign w_full = f_full(mask_i);
`else
  localparam int L = 32 / CHUNK_W;

  logic [31:0]        r_mask;
  logic [6:0]         r_acc;
  logic [5:0]         r_idx;
  logic [31:0]        w_shift;
  logic [CHUNK_W-1:0] w_chunk;
  logic               w_last;
  logic [6:0]         w_scan;

  assign w_shift = r_mask >> (32'(r_idx) * 32'(CHUNK_W));
  assign w_chunk = w_shift[CHUNK_W-1:0];
  assign w_last  = (r_idx == 6'(L - 1));

  // Fold the current chunk into the accumulator, LSB first; bit 31 only ever flags an error.
  always_comb begin
    w_scan = r_acc;
    for (int b = 0; b < CHUNK_W; b++) begin
      w_scan = f_step(w_scan, w_chunk[b], w_last && (b == CHUNK_W - 1));
    end
  end

  // Scan datapath: latch on accept, advance one chunk per SCAN cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mask <= 32'd0;
      r_acc  <= 7'd0;
      r_idx  <= 6'd0;
    end else if (r_state == ST_IDLE && valid_i) begin
      r_mask <= mask_i;
      r_acc  <= 7'd0;
      r_idx  <= 6'd0;
    end else if (r_state == ST_SCAN) begin
      r_acc  <= w_scan;
      r_idx  <= r_idx + 6'd1;
    end
  end
`endif

  // Next-state and result-load decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_res       = 6'd0;
    case (r_state)
      ST_IDLE: begin
        if (valid_i) begin
`ifdef ENC_THERMO_FAST_EN
          w_state_nxt = ST_DONE;
          w_load      = 1'b1;
          w_res       = {w_full[6], w_full[4:0]};
`else
          w_state_nxt = ST_SCAN;
`endif
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
`ifdef ENC_THERMO_FAST_EN
        w_state_nxt = ST_IDLE;
`else
        if (w_last) begin
          w_state_nxt = ST_DONE;
          w_load      = 1'b1;
          w_res       = {w_scan[6], w_scan[4:0]};
        end else begin
          w_state_nxt = ST_SCAN;
        end
`endif
      end
      ST_DONE: begin
        if (ready_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus registered handshake flags and result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_n     <= 5'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      r_valid <= (w_state_nxt == ST_DONE);
      if (w_load) begin
        r_n   <= w_res[4:0];
        r_err <= w_res[5];
      end
    end
  end

  assign ready_o = r_ready;
  assign valid_o = r_valid;
  assign n_o     = r_n;
  assign err_o   = r_err;

endmodule

// File: tb/tb_encode_thermo.sv
// Randomized self-checking bench for encode_thermo; instance 0 uses CHUNK_W=8, others sweep 1/16/32.
module tb_encode_thermo;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NI-1:0]   valid_a;
  logic [NI-1:0]   rdy_o_a;
  logic [NI-1:0]   vld_o_a;
  logic [NI-1:0]   rdy_i_a;
  logic [NI-1:0]   err_a;
  logic [31:0]     mask_a [NI];
  logic [4:0]      n_a    [NI];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CW = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 16 : 32;
    encode_thermo #(.CHUNK_W(CW)) u_dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (valid_a[g]),
      .ready_o (rdy_o_a[g]),
      .mask_i  (mask_a[g]),
      .valid_o (vld_o_a[g]),
      .ready_i (rdy_i_a[g]),
      .n_o     (n_a[g]),
      .err_o   (err_a[g])
    );
  end

  function automatic int cw_of(int k);
    case (k)
      0:       return 8;
      1:       return 1;
      2:       return 16;
      default: return 32;
    endcase
  endfunction

  // Edge index (after the accept edge E0) at which valid_o is first seen high.
  function automatic int exp_lat(int k);
`ifdef ENC_THERMO_FAST_EN
    return 0;
`else
    return 32 / cw_of(k);
`endif
  endfunction

  // Reference: count low ones over bits 30:0; legal only if the mask equals 2^n - 1.
  function automatic void model(input logic [31:0] m, output int n, output bit e);
    n = 0;
    while (n < 31 && m[n]) n++;
    e = (m != 32'((64'd1 << n) - 64'd1));
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(int k);
    int t = 0;
    while (!rdy_o_a[k] && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!rdy_o_a[k]) check("ready_timeout", {31'd0, rdy_o_a[k]}, 32'd1);
  endtask

  // Accept m on instance k, wait for valid_o, check latency and result.
  task automatic run_job(int k, logic [31:0] m, string tag, bit busy_hold);
    int lat;
    int en;
    bit ee;
    wait_ready(k);
    mask_a[k]  = m;
    valid_a[k] = 1'b1;
    @(posedge clk); #1;
    if (busy_hold) begin
      mask_a[k] = 32'h0000_FFFF;
    end else begin
      valid_a[k] = 1'b0;
      mask_a[k]  = $urandom;
    end
    lat = 0;
    while (!vld_o_a[k] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    model(m, en, ee);
    check({tag, "_lat"}, lat, exp_lat(k));
    check({tag, "_n"}, {27'd0, n_a[k]}, en);
    check({tag, "_err"}, {31'd0, err_a[k]}, {31'd0, ee});
  endtask

  task automatic finish_hs(int k, string tag);
    rdy_i_a[k] = 1'b1;
    @(posedge clk); #1;
    check({tag, "_rdy"}, {31'd0, rdy_o_a[k]}, 32'd1);
    check({tag, "_vld"}, {31'd0, vld_o_a[k]}, 32'd0);
  endtask

  initial begin
    logic [31:0] m;
    int          t;
    bit          seen;

    rst     = 1'b1;
    valid_a = '0;
    rdy_i_a = '1;
    for (int k = 0; k < NI; k++) mask_a[k] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_ready", {31'd0, rdy_o_a[k]}, 32'd1);
      check("rst_valid", {31'd0, vld_o_a[k]}, 32'd0);
      check("rst_n",     {27'd0, n_a[k]},     32'd0);
      check("rst_err",   {31'd0, err_a[k]},   32'd0);
    end
    rst = 1'b0;

    // Round trip on every CHUNK_W instance.
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 32; n++) begin
        m = 32'((64'd1 << n) - 64'd1);
        run_job(k, m, $sformatf("rt%0d_%0d", cw_of(k), n), 1'b0);
        finish_hs(k, "rt_hs");
      end
    end

    // Illegal masks.
    run_job(0, 32'h0000_0005, "ill_5", 1'b0);
    check("ill_5_nval", {27'd0, n_a[0]}, 32'd1);
    finish_hs(0, "ill_5_hs");
    run_job(0, 32'h8000_0000, "ill_top", 1'b0);
    check("ill_top_e", {31'd0, err_a[0]}, 32'd1);
    finish_hs(0, "ill_top_hs");
    run_job(0, 32'hFFFF_FFFF, "ill_ones", 1'b0);
    check("ill_ones_n", {27'd0, n_a[0]}, 32'd31);
    finish_hs(0, "ill_ones_hs");

    // Backpressure.
    rdy_i_a[0] = 1'b0;
    run_job(0, 32'h0000_00FF, "bp", 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_vld", {31'd0, vld_o_a[0]}, 32'd1);
      check("bp_n",   {27'd0, n_a[0]},     32'd8);
      check("bp_rdy", {31'd0, rdy_o_a[0]}, 32'd0);
    end
    finish_hs(0, "bp_rel");

    // Busy input ignored: second mask is held on valid_i through the first job.
    run_job(0, 32'h0000_0003, "busy1", 1'b1);
    @(posedge clk); #1;
    check("busy_idle", {31'd0, rdy_o_a[0]}, 32'd1);
    run_job(0, 32'h0000_FFFF, "busy2", 1'b0);
    check("busy2_n16", {27'd0, n_a[0]}, 32'd16);
    finish_hs(0, "busy2_hs");

    // Reset during SCAN chunk 2 discards the job.
    rdy_i_a[0] = 1'b0;
    wait_ready(0);
    mask_a[0]  = 32'h0000_0FFF;
    valid_a[0] = 1'b1;
    @(posedge clk); #1;
    valid_a[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_vld", {31'd0, vld_o_a[0]}, 32'd0);
    check("mrst_rdy", {31'd0, rdy_o_a[0]}, 32'd1);
    check("mrst_n",   {27'd0, n_a[0]},     32'd0);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen = seen | vld_o_a[0];
    end
    check("mrst_noresult", {31'd0, seen}, 32'd0);
    rdy_i_a[0] = 1'b1;

    // Random masks: legal, single-bit corruptions of legal, and arbitrary.
    for (int i = 0; i < 60; i++) begin
      t = $urandom_range(0, 31);
      m = 32'((64'd1 << t) - 64'd1);
      case ($urandom_range(0, 2))
        0:       m = m;
        1:       m = m ^ (32'd1 << $urandom_range(0, 31));
        default: m = $urandom;
      endcase
      run_job(0, m, $sformatf("rnd%0d", i), 1'b0);
      finish_hs(0, "rnd_hs");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
